// File: rtl/bypass_pkg.sv
// Shared tag types, select encodings and match helper for the operand bypass network.
package bypass_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] SEL_REGFILE = 2'd0;
  localparam logic [1:0] SEL_MEM     = 2'd1;
  localparam logic [1:0] SEL_WB      = 2'd2;
  localparam logic [1:0] SEL_RET     = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } stage_tag_t;

  // r0 is hardwired, so a write to it is never a forwarding source.
  function automatic logic tag_match(input stage_tag_t t, input logic [REG_W-1:0] s);
    return t.valid & t.we & (t.rd != '0) & (t.rd == s);
  endfunction

endpackage

// File: rtl/bypass_stage_reg.sv
// One pipeline tag register: async active-low reset, hold enable, synchronous valid clear.
module bypass_stage_reg #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Clear only drops valid; the tag fields simply hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (clr_i)     valid_q <= 1'b0;
      else if (en_i) valid_q <= valid_i;
      if (en_i)      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bypass_select_unit.sv
// Forwarding control: tracks X/M/W(/R) destination tags, drives ALU operand selects and load-use stall.
// BYPASS_RETIRE_EN adds the R stage and select 3; otherwise the regfile must write-before-read.
module bypass_select_unit
  import bypass_pkg::*;
#(
  parameter int REG_W = bypass_pkg::REG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_we,
  input  logic             d_load,
  input  logic             stall_in,
  input  logic             flush,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             hazard_stall
);

  localparam int XW = 3*REG_W + 2;
  localparam int MW = REG_W + 2;
  localparam int WW = REG_W + 1;

  logic             adv;
  logic             x_valid_d;
  logic             x_v, m_v, w_v;
  logic [XW-1:0]    x_data;
  logic [MW-1:0]    m_data;
  logic [WW-1:0]    w_data;
  logic [REG_W-1:0] x_rs, x_rt, x_rd;
  logic             x_we, x_load;
  stage_tag_t       m_tag, w_tag;

  assign adv = ~stall_in;
  assign x_valid_d = d_valid & ~flush & ~hazard_stall;

  bypass_stage_reg #(.W(XW)) u_x (
    .clock(clock), .reset(reset), .en_i(adv), .clr_i(stall_in & flush),
    .valid_i(x_valid_d), .data_i({d_rs, d_rt, d_rd, d_we, d_load}),
    .valid_o(x_v), .data_o(x_data)
  );

  assign {x_rs, x_rt, x_rd, x_we, x_load} = x_data;

  bypass_stage_reg #(.W(MW)) u_m (
    .clock(clock), .reset(reset), .en_i(adv), .clr_i(1'b0),
    .valid_i(x_v), .data_i({x_rd, x_we, x_load}),
    .valid_o(m_v), .data_o(m_data)
  );

  bypass_stage_reg #(.W(WW)) u_w (
    .clock(clock), .reset(reset), .en_i(adv), .clr_i(1'b0),
    .valid_i(m_v), .data_i(m_data[MW-1:1]),
    .valid_o(w_v), .data_o(w_data)
  );

  assign m_tag = '{valid: m_v, rd: m_data[MW-1:2], we: m_data[1], load: m_data[0]};
  assign w_tag = '{valid: w_v, rd: w_data[WW-1:1], we: w_data[0], load: 1'b0};

`ifdef BYPASS_RETIRE_EN
  logic          r_v;
  logic [WW-1:0] r_data;
  stage_tag_t    r_tag;

  bypass_stage_reg #(.W(WW)) u_r (
    .clock(clock), .reset(reset), .en_i(adv), .clr_i(1'b0),
    .valid_i(w_v), .data_i(w_data),
    .valid_o(r_v), .data_o(r_data)
  );

  assign r_tag = '{valid: r_v, rd: r_data[WW-1:1], we: r_data[0], load: 1'b0};
`endif

  // A load's data is not ready in M, so it is never picked there.
  function automatic logic [1:0] pick_sel(input logic xv, input stage_tag_t m,
                                          input stage_tag_t w, input logic [REG_W-1:0] s);
    logic [1:0] sel;
    sel = SEL_REGFILE;
    if (xv) begin
      if (tag_match(m, s) && !m.load) sel = SEL_MEM;
      else if (tag_match(w, s))       sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    sel_a = pick_sel(x_v, m_tag, w_tag, x_rs);
    sel_b = pick_sel(x_v, m_tag, w_tag, x_rt);
`ifdef BYPASS_RETIRE_EN
    if (x_v && sel_a == SEL_REGFILE && tag_match(r_tag, x_rs)) sel_a = SEL_RET;
    if (x_v && sel_b == SEL_REGFILE && tag_match(r_tag, x_rt)) sel_b = SEL_RET;
`endif
  end

  assign hazard_stall = x_v & x_load & x_we & (x_rd != '0) & d_valid &
                        ((d_rs == x_rd) | (d_rt == x_rd));

endmodule
